// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: conditions four raw car-presence sensors into clean traffic requests.
//
// Each channel synchronises its raw input, debounces it, and stretches the falling edge of
// the debounced value by HOLD_CYCLES so a car briefly lost by the sensor does not drop its
// request. The four channels are identical and fully independent.
//
// Build option:
//   TL_SENSOR_SYNC_EN  defined   -> two-flop synchroniser on every raw input
//                      undefined -> raw inputs feed the debouncer directly (two edges less
//                                   latency on both rise and fall)
//
// Parameters:
//   DB_CYCLES    consecutive disagreeing samples needed to flip the debounced value (1..15)
//   HOLD_CYCLES  extra cycles a request stays high after its debounced value falls (0..255)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   synchronous reset, active HIGH despite the name
//   raw_a     in   street A sensor
//   raw_al    in   street A left-turn sensor
//   raw_b     in   street B sensor
//   raw_bl    in   street B left-turn sensor
//   Ta        out  conditioned request for raw_a
//   Tal       out  conditioned request for raw_al
//   Tb        out  conditioned request for raw_b
//   Tbl       out  conditioned request for raw_bl

module tl_sensor_cond #(
   parameter int unsigned DB_CYCLES   = 4,
   parameter int unsigned HOLD_CYCLES = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_a,
   input  logic raw_al,
   input  logic raw_b,
   input  logic raw_bl,
   output logic Ta,
   output logic Tal,
   output logic Tb,
   output logic Tbl
);

   localparam int unsigned NumCh = 4;

   // Counter value on which the next disagreeing sample flips the debounced bit.
   localparam logic [3:0] DbLast   = 4'(DB_CYCLES - 1);
   localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES);

   // Channel order: 0 = A, 1 = A-left, 2 = B, 3 = B-left.
   logic [NumCh-1:0] raw;
   logic [NumCh-1:0] s;

   assign raw = {raw_bl, raw_b, raw_al, raw_a};

   // ------------------------------------------------------------------------------------------
   // Input synchroniser
   // ------------------------------------------------------------------------------------------
`ifdef TL_SENSOR_SYNC_EN
   logic [NumCh-1:0] sync1_q;
   logic [NumCh-1:0] sync2_q;

   always_ff @(posedge clk) begin
      if (reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = raw;
`endif

   // ------------------------------------------------------------------------------------------
   // Debounce and hold state
   // ------------------------------------------------------------------------------------------
   logic [NumCh-1:0]      db_q;
   logic [NumCh-1:0]      db_d;
   logic [NumCh-1:0][3:0] dcnt_q;
   logic [NumCh-1:0][3:0] dcnt_d;
   logic [NumCh-1:0][7:0] hcnt_q;
   logic [NumCh-1:0][7:0] hcnt_d;

   always_comb begin
      db_d   = db_q;
      dcnt_d = dcnt_q;
      hcnt_d = hcnt_q;

      for (int i = 0; i < NumCh; i++) begin
         // dcnt counts consecutive samples that disagree with db; any agreeing sample
         // restarts the count, which is what rejects short glitches.
         if (s[i] == db_q[i]) begin
            dcnt_d[i] = '0;
         end else if (dcnt_q[i] == DbLast) begin
            db_d[i]   = s[i];
            dcnt_d[i] = '0;
         end else begin
            dcnt_d[i] = dcnt_q[i] + 4'd1;
         end

         // Hold timer arms on the debounced fall and is cancelled by a debounced rise.
         if (db_q[i] && !db_d[i]) begin
            hcnt_d[i] = HoldLoad;
         end else if (!db_q[i] && db_d[i]) begin
            hcnt_d[i] = '0;
         end else if (!db_q[i] && (hcnt_q[i] != '0)) begin
            hcnt_d[i] = hcnt_q[i] - 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         db_q   <= '0;
         dcnt_q <= '0;
         hcnt_q <= '0;
      end else begin
         db_q   <= db_d;
         dcnt_q <= dcnt_d;
         hcnt_q <= hcnt_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs: decoded from flops only
   // ------------------------------------------------------------------------------------------
   logic [NumCh-1:0] req;

   always_comb begin
      req = '0;
      for (int i = 0; i < NumCh; i++) begin
         req[i] = db_q[i] | (hcnt_q[i] != '0);
      end
   end

   assign Ta  = req[0];
   assign Tal = req[1];
   assign Tb  = req[2];
   assign Tbl = req[3];

endmodule

// File: doc/tl_sensor_cond.md
TL_SENSOR_COND -- requirements
Module: tl_sensor_cond

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4: the number of consecutive disagreeing samples needed to change a debounced value (legal range 1..15).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 8: the number of extra cycles an output stays 1 after its debounced value falls (legal range 0..255).
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-high reset; value 1 at a rising clk edge resets the block.
REQ-005 raw_a, raw_al, raw_b, raw_bl  input  1 each  unsynchronised car-presence sensors: street A, A-left-turn, street B, B-left-turn.
REQ-006 Ta, Tal, Tb, Tbl  output  1 each  conditioned traffic requests for the downstream traffic-light controller, one per raw input in the same order.

Function
REQ-007 The block SHALL process the four channels independently and identically; no channel's state SHALL affect another.
REQ-008 Each channel SHALL sample its raw input through a two-flop synchroniser; the synchronised value s SHALL lag raw by 2 edges.
REQ-009 Each channel SHALL keep a debounced bit db and a 4-bit stability counter dcnt.
REQ-010 Counter and db update:
- s == db: dcnt is cleared to 0.
- s != db and dcnt == DB_CYCLES-1: db takes s and dcnt is cleared to 0.
- s != db otherwise: dcnt increments.
REQ-011 Each channel SHALL keep an 8-bit hold counter hcnt.
- Edge where db goes 1->0: hcnt loads HOLD_CYCLES.
- Edge where db goes 0->1: hcnt is cleared to 0.
- Otherwise, while hcnt != 0 and db == 0: hcnt decrements by 1 and does not go below 0.
REQ-012 Each output SHALL equal db OR (hcnt != 0), decoded only from flop outputs, with no combinational path from any raw input.
REQ-013 Rise latency: a raw 0->1 held stable SHALL drive the output to 1 exactly DB_CYCLES+2 edges after the edge that first samples it.
REQ-014 Fall latency: a raw 1->0 held stable SHALL keep the output at 1 for exactly DB_CYCLES+2+HOLD_CYCLES edges, then drive it to 0.
REQ-015 Glitch rejection: a raw pulse shorter than DB_CYCLES synchronised samples SHALL NOT change db or any output.
REQ-016 Re-assertion during hold: if db returns to 1 while hcnt != 0, the output SHALL stay 1 continuously with no 0 cycle.
REQ-017 When HOLD_CYCLES == 0, the output SHALL follow db exactly.

Reset
REQ-018 On reset, all synchroniser flops, db, dcnt and hcnt SHALL clear to 0, so Ta, Tal, Tb and Tbl are 0 on the first cycle after the reset edge.
REQ-019 A reset asserted mid-debounce or mid-hold SHALL abandon that activity immediately.
REQ-020 Reset SHALL take priority over all other updates.
REQ-021 After reset releases, each channel SHALL restart the full latency of REQ-013 from the synchroniser.

Configuration
REQ-022 Macro TL_SENSOR_SYNC_EN controls the synchroniser.
- Defined: the two-flop synchroniser of REQ-008 is present.
- Undefined: the synchroniser is removed, s equals raw directly, and the REQ-013/REQ-014 latencies each drop by 2 edges (rise = DB_CYCLES).
- All other behaviour is identical in both builds.

Verification
All scenarios use DB_CYCLES=4, HOLD_CYCLES=8 and TL_SENSOR_SYNC_EN defined unless stated.
REQ-023 Reset, then raw_a=1 held from edge 0 -> Ta=1 first after edge 6; Tal, Tb and Tbl stay 0.
REQ-024 Then raw_a=0 held -> Ta stays 1 through edge 13 after the fall and is 0 after edge 14.
REQ-025 raw_b pulses high for 3 cycles from idle -> Tb stays 0 throughout; the dcnt of channel b returns to 0.
REQ-026 raw_al falls, then returns to 1 after 9 cycles (during hold) -> Tal never drops to 0.
REQ-027 All four raw inputs at 1 for 20 cycles, then reset_n=1 for one cycle with the raw inputs still high -> all outputs 0 the cycle after reset, then back to 1 exactly 6 edges after reset release.
REQ-028 Build without TL_SENSOR_SYNC_EN, raw_bl rises -> Tbl=1 after edge 4; with HOLD_CYCLES=0, Tbl falls exactly 4 edges after raw_bl falls.
